// File: rtl/debounce_pkg.sv
// Shared state encoding and default tuning for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L} db_state_t;

  localparam int DB_SYNC_STAGES  = 2;
  localparam int DB_STABLE_COUNT = 50000;

endpackage

// File: rtl/sync_chain.sv
// Falling-edge shift chain bringing an asynchronous 1-bit pin into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(negedge clk) begin
    if (rst) chain_reg <= '0;
    else     chain_reg <= {chain_reg[STAGES-2:0], d};
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button pin: synchroniser, qualification FSM with sample counter,
// and registered level / rise / fall / busy outputs, all on the falling clock edge.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = DB_SYNC_STAGES,
  parameter int STABLE_COUNT = DB_STABLE_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_busy
);

  localparam int CNT_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < 2 || STABLE_COUNT < 2) begin : g_param_check
    $error("button_debouncer: SYNC_STAGES and STABLE_COUNT must both be >= 2");
  end

  logic             s_in;
  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             busy_reg, busy_next;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s_in)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      busy_reg  <= busy_next;
    end
  end

  // The WAIT count holds samples already seen; the edge taking the last one commits.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state_reg)
      S_LOW: begin
        if (s_in) begin
          cnt_next   = CNT_ONE;
          state_next = S_WAIT_H;
        end
      end
      S_WAIT_H: begin
        if (!s_in) begin
          cnt_next   = '0;
          state_next = S_LOW;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = S_HIGH;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!s_in) begin
          cnt_next   = CNT_ONE;
          state_next = S_WAIT_L;
        end
      end
      S_WAIT_L: begin
        if (s_in) begin
          cnt_next   = '0;
          state_next = S_HIGH;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = S_LOW;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = S_LOW;
        level_next = 1'b0;
      end
    endcase
    busy_next = (state_next == S_WAIT_H) || (state_next == S_WAIT_L);
  end

  assign btn_level = level_reg;
  assign btn_rise  = rise_reg;
  assign btn_fall  = fall_reg;
  assign btn_busy  = busy_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, STABLE_COUNT=4; each step
// waits one falling edge and checks the registered outputs against hand-derived values.
module tb_button_debouncer;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level, btn_rise, btn_fall, btn_busy;

  int n_cmp = 0;
  int n_err = 0;

  button_debouncer #(.SYNC_STAGES(2), .STABLE_COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_busy  (btn_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one falling edge, then check level/rise/fall/busy.
  task automatic edge_chk(input string tag, input logic lv, input logic rs,
                          input logic fl, input logic bs);
    @(negedge clk);
    #1;
    chk({tag, ".level"}, 32'(btn_level), 32'(lv));
    chk({tag, ".rise"},  32'(btn_rise),  32'(rs));
    chk({tag, ".fall"},  32'(btn_fall),  32'(fl));
    chk({tag, ".busy"},  32'(btn_busy),  32'(bs));
    $display("%s: level=%b rise=%b fall=%b busy=%b", tag, btn_level, btn_rise, btn_fall, btn_busy);
  endtask

  task automatic fsm_chk(input string tag, input db_state_t st, input int cnt);
    chk({tag, ".state"}, 32'(dut.state_reg), 32'(st));
    chk({tag, ".cnt"},   32'(dut.cnt_reg),   32'(cnt));
  endtask

  initial begin
    // 1: reset with the pin held high
    rst = 1'b1;
    btn_in = 1'b1;
    edge_chk("t1_rst_e1", 0, 0, 0, 0);
    edge_chk("t1_rst_e2", 0, 0, 0, 0);
    edge_chk("t1_rst_e3", 0, 0, 0, 0);
    fsm_chk("t1_rst", S_LOW, 0);
    rst = 1'b0;
    btn_in = 1'b0;
    edge_chk("t1_idle_e1", 0, 0, 0, 0);
    edge_chk("t1_idle_e2", 0, 0, 0, 0);
    edge_chk("t1_idle_e3", 0, 0, 0, 0);

    // 2: clean press
    btn_in = 1'b1;
    edge_chk("t2_e1", 0, 0, 0, 0);
    edge_chk("t2_e2", 0, 0, 0, 0);
    edge_chk("t2_e3", 0, 0, 0, 1);
    fsm_chk("t2_e3", S_WAIT_H, 1);
    edge_chk("t2_e4", 0, 0, 0, 1);
    edge_chk("t2_e5", 0, 0, 0, 1);
    fsm_chk("t2_e5", S_WAIT_H, 3);
    edge_chk("t2_e6", 1, 1, 0, 0);
    fsm_chk("t2_e6", S_HIGH, 0);
    edge_chk("t2_e7", 1, 0, 0, 0);
    edge_chk("t2_e8", 1, 0, 0, 0);

    // 4: clean release from S_HIGH
    btn_in = 1'b0;
    edge_chk("t4_e1", 1, 0, 0, 0);
    edge_chk("t4_e2", 1, 0, 0, 0);
    edge_chk("t4_e3", 1, 0, 0, 1);
    edge_chk("t4_e4", 1, 0, 0, 1);
    edge_chk("t4_e5", 1, 0, 0, 1);
    edge_chk("t4_e6", 0, 0, 1, 0);
    edge_chk("t4_e7", 0, 0, 0, 0);
    edge_chk("t4_e8", 0, 0, 0, 0);

    // 3: bounce one sample short of acceptance
    btn_in = 1'b1;
    edge_chk("t3_e1", 0, 0, 0, 0);
    edge_chk("t3_e2", 0, 0, 0, 0);
    edge_chk("t3_e3", 0, 0, 0, 1);
    btn_in = 1'b0;
    edge_chk("t3_e4", 0, 0, 0, 1);
    edge_chk("t3_e5", 0, 0, 0, 1);
    fsm_chk("t3_e5", S_WAIT_H, 3);
    edge_chk("t3_e6", 0, 0, 0, 0);
    fsm_chk("t3_e6", S_LOW, 0);
    edge_chk("t3_e7", 0, 0, 0, 0);
    edge_chk("t3_e8", 0, 0, 0, 0);

    // 6: reach S_HIGH, then a 2-cycle low glitch
    btn_in = 1'b1;
    edge_chk("t6_p1", 0, 0, 0, 0);
    edge_chk("t6_p2", 0, 0, 0, 0);
    edge_chk("t6_p3", 0, 0, 0, 1);
    edge_chk("t6_p4", 0, 0, 0, 1);
    edge_chk("t6_p5", 0, 0, 0, 1);
    edge_chk("t6_p6", 1, 1, 0, 0);
    edge_chk("t6_p7", 1, 0, 0, 0);
    btn_in = 1'b0;
    edge_chk("t6_g1", 1, 0, 0, 0);
    edge_chk("t6_g2", 1, 0, 0, 0);
    btn_in = 1'b1;
    edge_chk("t6_g3", 1, 0, 0, 1);
    fsm_chk("t6_g3", S_WAIT_L, 1);
    edge_chk("t6_g4", 1, 0, 0, 1);
    edge_chk("t6_g5", 1, 0, 0, 0);
    fsm_chk("t6_g5", S_HIGH, 0);
    edge_chk("t6_g6", 1, 0, 0, 0);
    edge_chk("t6_g7", 1, 0, 0, 0);

    // return to S_LOW before the reset test
    btn_in = 1'b0;
    edge_chk("t5_r1", 1, 0, 0, 0);
    edge_chk("t5_r2", 1, 0, 0, 0);
    edge_chk("t5_r3", 1, 0, 0, 1);
    edge_chk("t5_r4", 1, 0, 0, 1);
    edge_chk("t5_r5", 1, 0, 0, 1);
    edge_chk("t5_r6", 0, 0, 1, 0);
    edge_chk("t5_r7", 0, 0, 0, 0);

    // 5: press, reset on edge 4 mid-qualification, keep pressing
    btn_in = 1'b1;
    edge_chk("t5_e1", 0, 0, 0, 0);
    edge_chk("t5_e2", 0, 0, 0, 0);
    edge_chk("t5_e3", 0, 0, 0, 1);
    rst = 1'b1;
    edge_chk("t5_e4_rst", 0, 0, 0, 0);
    fsm_chk("t5_e4_rst", S_LOW, 0);
    rst = 1'b0;
    edge_chk("t5_a1", 0, 0, 0, 0);
    edge_chk("t5_a2", 0, 0, 0, 0);
    edge_chk("t5_a3", 0, 0, 0, 1);
    edge_chk("t5_a4", 0, 0, 0, 1);
    edge_chk("t5_a5", 0, 0, 0, 1);
    edge_chk("t5_a6", 1, 1, 0, 0);
    edge_chk("t5_a7", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
